// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver with mid-bit sampling, valid/ack hold output and overrun flag.
// Optional even-parity (8E1) framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx_deframer #(
  parameter int BIT_CYCLES  = 868,
  parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       ack_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);
  localparam int CW = $clog2(BIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_HIGH
  } state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tick_half, tick_bit;
  logic            byte_done, frame_bad, parity_bad;

  assign tick_half = (cnt == CW'(HALF_CYCLES - 1));
  assign tick_bit  = (cnt == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick_half) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (tick_bit && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:    if (tick_bit) state_nxt = STOP;
`else
      DATA:      if (tick_bit && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:      if (tick_bit) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk_i) begin
    if (rst_i)                          par_bit <= 1'b0;
    else if (state == PARITY && tick_bit) par_bit <= rx_s;
  end
`endif

  always_comb begin
    busy_o     = (state != IDLE);
    byte_done  = (state == STOP) && tick_bit && rx_s;
    frame_bad  = (state == STOP) && tick_bit && !rx_s;
`ifdef UART_RX_PARITY_EN
    parity_bad = byte_done && (par_bit != ^shreg);
`else
    parity_bad = 1'b0;
`endif
  end

  // cnt counts cycles since the last sample point; it restarts at each sample
  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
    end else if ((state == START && tick_half) || tick_bit) begin
      cnt <= '0;
      if (state == DATA) bit_idx <= bit_idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                          shreg <= 8'h00;
    else if (state == DATA && tick_bit) shreg <= {rx_s, shreg[7:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= frame_bad;
      if (byte_done) begin
        if (!valid_o || ack_i) begin
          data_o  <= shreg;
          valid_o <= 1'b1;
          if (ack_i) overrun_o <= 1'b0;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ack_i) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) parity_err_o <= 1'b0;
    else       parity_err_o <= parity_bad;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
